// File: rtl/fnv1a_stream_hasher.sv
// rtl/fnv1a_stream_hasher.sv - FNV-1a 32-bit hasher draining a fall-through byte FIFO
module fnv1a_stream_hasher #(
    parameter int          DSIZE        = 9,
    parameter logic [31:0] OFFSET_BASIS = 32'h811C9DC5,
    parameter logic [31:0] FNV_PRIME    = 32'h01000193,
    parameter int          CNT_WIDTH    = 16
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic [DSIZE-1:0]     rdata,
    input  logic                 rempty,
    output logic                 rinc,
    input  logic                 soft_clr,
    output logic [31:0]          digest,
    output logic                 digest_valid,
    input  logic                 digest_ready,
    output logic [CNT_WIDTH-1:0] byte_count,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, state_d;
    logic [31:0]          hash, hash_d;
    logic [7:0]           byte_q, byte_d;
    logic                 last_q, last_d;
    logic [31:0]          digest_d;
    logic                 digest_valid_d;
    logic [CNT_WIDTH-1:0] count_d;
    logic [31:0]          mix_x;
    logic [31:0]          mixed;

    assign mix_x = hash ^ {24'b0, byte_q};

    // The standard prime maps onto six shifted adds; any other prime falls back to a multiply.
    generate
        if (FNV_PRIME == 32'h01000193) begin : g_shift_add
            assign mixed = mix_x + (mix_x << 1) + (mix_x << 4) + (mix_x << 7)
                         + (mix_x << 8) + (mix_x << 24);
        end else begin : g_mult
            assign mixed = mix_x * FNV_PRIME;
        end
    endgenerate

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state        <= IDLE;
            hash         <= OFFSET_BASIS;
            byte_q       <= 8'h00;
            last_q       <= 1'b0;
            digest       <= 32'h0;
            digest_valid <= 1'b0;
            byte_count   <= '0;
        end else begin
            state        <= state_d;
            hash         <= hash_d;
            byte_q       <= byte_d;
            last_q       <= last_d;
            digest       <= digest_d;
            digest_valid <= digest_valid_d;
            byte_count   <= count_d;
        end
    end

    always_comb begin
        state_d        = state;
        hash_d         = hash;
        byte_d         = byte_q;
        last_d         = last_q;
        digest_d       = digest;
        digest_valid_d = digest_valid;
        count_d        = byte_count;
        rinc           = 1'b0;
        case (state)
            IDLE: begin
                if (soft_clr) begin
                    hash_d  = OFFSET_BASIS;
                    count_d = '0;
                end else if (!rempty) begin
                    rinc    = rrst_n;
                    byte_d  = rdata[7:0];
                    last_d  = rdata[DSIZE-1];
                    state_d = MIX;
                end
            end
            MIX: begin
                if (soft_clr) begin
                    // The popped byte is dropped; the FIFO entry cannot be returned.
                    hash_d  = OFFSET_BASIS;
                    count_d = '0;
                    state_d = IDLE;
                end else begin
                    hash_d = mixed;
                    if (byte_count != {CNT_WIDTH{1'b1}}) begin
                        count_d = byte_count + 1'b1;
                    end
                    if (last_q) begin
                        digest_d       = mixed;
                        digest_valid_d = 1'b1;
                        state_d        = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                if (digest_ready) begin
                    digest_valid_d = 1'b0;
                    hash_d         = OFFSET_BASIS;
                    count_d        = '0;
                    state_d        = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE) || (byte_count != '0);

endmodule

// File: tb/tb_fnv1a_stream_hasher.sv
// tb/tb_fnv1a_stream_hasher.sv - directed and randomized checks for fnv1a_stream_hasher
module tb_fnv1a_stream_hasher;

    logic        rclk;
    logic        rrst_n;
    logic [8:0]  rdata;
    logic        rempty;
    logic        rinc;
    logic        soft_clr;
    logic [31:0] digest;
    logic        digest_valid;
    logic        digest_ready;
    logic [15:0] byte_count;
    logic        busy;

    fnv1a_stream_hasher dut (
        .rclk         (rclk),
        .rrst_n       (rrst_n),
        .rdata        (rdata),
        .rempty       (rempty),
        .rinc         (rinc),
        .soft_clr     (soft_clr),
        .digest       (digest),
        .digest_valid (digest_valid),
        .digest_ready (digest_ready),
        .byte_count   (byte_count),
        .busy         (busy)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [8:0]  fifo_q[$];
    logic [31:0] exp_d[$];
    logic [15:0] exp_c[$];
    int          pushed   = 0;
    int          flushed  = 0;
    int          pops     = 0;
    int          viol     = 0;
    logic        pop_s    = 1'b0;
    logic        stall    = 1'b0;
    logic        rand_mode = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic update_ports();
        rempty = (fifo_q.size() == 0) || stall;
        rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 9'h000;
    endtask

    function automatic logic [31:0] fnv_ref(input logic [31:0] h, input logic [7:0] b);
        return (h ^ {24'h0, b}) * 32'h01000193;
    endfunction

    task automatic push_msg(input string s, input bit last_at_end, input bit expect_it);
        logic [31:0] h;
        h = 32'h811C9DC5;
        for (int i = 0; i < s.len(); i++) begin
            fifo_q.push_back({(last_at_end && i == s.len() - 1), s[i]});
            h = fnv_ref(h, s[i]);
        end
        pushed += s.len();
        if (expect_it) begin
            exp_d.push_back(h);
            exp_c.push_back(16'(s.len()));
        end
        update_ports();
    endtask

    task automatic wait_valid(input string tag, input int limit);
        int n;
        n = 0;
        while (!digest_valid && n < limit) begin
            @(negedge rclk);
            n++;
        end
        check(tag, {31'h0, digest_valid}, 32'h1);
    endtask

    task automatic wait_drain(input string tag, input int limit);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || busy || exp_d.size() != 0) && n < limit) begin
            @(negedge rclk);
            n++;
        end
        check(tag, {31'h0, (n < limit)}, 32'h1);
    endtask

    // Fall-through FIFO model: the pop seen at the falling edge retires the head after the next rise.
    always @(posedge rclk) begin
        #1;
        if (pop_s && fifo_q.size() != 0) void'(fifo_q.pop_front());
        stall = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        update_ports();
    end

    // Scoreboard: each accepted digest is compared against the oldest expected one.
    always @(negedge rclk) begin
        pop_s = rinc;
        if (rinc) pops++;
        if (rinc && rempty) viol++;
        if (rrst_n && digest_valid && digest_ready) begin
            if (exp_d.size() == 0) begin
                check("sb_unexpected_digest", exp_d.size(), 32'd1);
            end else begin
                check("sb_digest", digest, exp_d.pop_front());
                check("sb_byte_count", {16'h0, byte_count}, {16'h0, exp_c.pop_front()});
            end
        end
    end

    initial begin
        rrst_n       = 1'b0;
        soft_clr     = 1'b0;
        digest_ready = 1'b0;
        update_ports();
        repeat (3) @(posedge rclk);
        #1;
        check("rst_digest_valid", {31'h0, digest_valid}, 32'h0);
        check("rst_digest", digest, 32'h0);
        check("rst_byte_count", {16'h0, byte_count}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_rinc", {31'h0, rinc}, 32'h0);
        rrst_n = 1'b1;

        // Single byte "a": one pop, digest two cycles after the pop cycle.
        @(posedge rclk); #1;
        push_msg("a", 1'b1, 1'b1);
        @(negedge rclk);
        check("a_pop_cycle_rinc", {31'h0, rinc}, 32'h1);
        @(negedge rclk);
        check("a_mix_rinc", {31'h0, rinc}, 32'h0);
        check("a_mix_valid", {31'h0, digest_valid}, 32'h0);
        @(negedge rclk);
        check("a_valid_latency", {31'h0, digest_valid}, 32'h1);
        check("a_digest", digest, 32'hE40C292C);
        check("a_byte_count", {16'h0, byte_count}, 32'd1);
        check("a_busy", {31'h0, busy}, 32'h1);
        @(posedge rclk); #1;
        digest_ready = 1'b1;
        @(negedge rclk);
        @(negedge rclk);
        check("a_valid_dropped", {31'h0, digest_valid}, 32'h0);
        check("a_digest_holds", digest, 32'hE40C292C);
        check("a_count_cleared", {16'h0, byte_count}, 32'd0);

        // "foobar" with ready held high.
        @(posedge rclk); #1;
        push_msg("foobar", 1'b1, 1'b1);
        wait_valid("foobar_valid_timeout", 100);
        @(negedge rclk);
        check("foobar_valid_after_accept", {31'h0, digest_valid}, 32'h0);
        check("foobar_count_after_accept", {16'h0, byte_count}, 32'd0);
        check("foobar_pops", pops, 32'd7);

        // Two messages back to back; first digest held while ready is low.
        @(posedge rclk); #1;
        digest_ready = 1'b0;
        push_msg("a", 1'b1, 1'b1);
        push_msg("foobar", 1'b1, 1'b1);
        wait_valid("bb_valid_timeout", 100);
        for (int i = 0; i < 20; i++) begin
            @(negedge rclk);
            check("bb_hold_valid", {31'h0, digest_valid}, 32'h1);
            check("bb_hold_digest", digest, 32'hE40C292C);
            check("bb_no_pop_in_done", {31'h0, rinc}, 32'h0);
        end
        check("bb_fifo_untouched", fifo_q.size(), 32'd6);
        @(posedge rclk); #1;
        digest_ready = 1'b1;
        wait_drain("bb_drain_timeout", 200);

        // Partial "fo" aborted by soft_clr leaves no residue.
        @(posedge rclk); #1;
        push_msg("fo", 1'b0, 1'b0);
        repeat (8) @(negedge rclk);
        check("fo_partial_count", {16'h0, byte_count}, 32'd2);
        check("fo_partial_busy", {31'h0, busy}, 32'h1);
        @(posedge rclk); #1;
        soft_clr = 1'b1;
        @(posedge rclk); #1;
        soft_clr = 1'b0;
        @(negedge rclk);
        check("clr_count", {16'h0, byte_count}, 32'd0);
        check("clr_busy", {31'h0, busy}, 32'h0);
        push_msg("a", 1'b1, 1'b1);
        wait_drain("clr_drain_timeout", 100);

        // soft_clr in the same IDLE cycle as a ready head entry blocks the pop.
        @(posedge rclk); #1;
        soft_clr = 1'b1;
        push_msg("a", 1'b1, 1'b1);
        @(negedge rclk);
        check("clr_blocks_pop", {31'h0, rinc}, 32'h0);
        @(posedge rclk); #1;
        soft_clr = 1'b0;
        wait_drain("clr_pop_drain_timeout", 100);

        // Asynchronous reset during MIX of "foobar".
        @(posedge rclk); #1;
        push_msg("foobar", 1'b1, 1'b0);
        begin
            int n;
            n = 0;
            while (!rinc && n < 50) begin
                @(negedge rclk);
                n++;
            end
            check("rst_mid_pop_timeout", {31'h0, rinc}, 32'h1);
        end
        @(posedge rclk); #1;
        rrst_n = 1'b0;
        #1;
        check("arst_valid", {31'h0, digest_valid}, 32'h0);
        check("arst_digest", digest, 32'h0);
        check("arst_count", {16'h0, byte_count}, 32'd0);
        check("arst_busy", {31'h0, busy}, 32'h0);
        check("arst_rinc", {31'h0, rinc}, 32'h0);
        flushed += fifo_q.size();
        fifo_q.delete();
        update_ports();
        @(posedge rclk); #1;
        rrst_n = 1'b1;
        push_msg("a", 1'b1, 1'b1);
        wait_drain("arst_drain_timeout", 100);

        // Random rempty stalls with random messages.
        @(posedge rclk); #1;
        rand_mode = 1'b1;
        for (int m = 0; m < 4; m++) begin
            string s;
            int    len;
            s   = "";
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) s = {s, string'(8'($urandom_range(1, 255)))};
            push_msg(s, 1'b1, 1'b1);
        end
        wait_drain("rand_drain_timeout", 2000);
        rand_mode = 1'b0;

        check("rinc_while_empty", viol, 32'd0);
        check("pop_per_byte", pops, pushed - flushed);
        check("sb_empty", exp_d.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fnv1a_stream_hasher.md
Name: fnv1a_stream_hasher

Overview:
Read-domain consumer on the rclk side of the byte FIFO. It pops entries while the FIFO is configured FALLTHROUGH="TRUE", with DSIZE=9: bit 8 is an end-of-message flag and bits 7:0 are data. It folds each byte into a 32-bit FNV-1a hash. On the flagged byte it presents the digest with a valid/ready handshake to the I2C register/readout logic.

Parameters:
DSIZE, 9, FIFO entry width; bit DSIZE-1 is the last flag, bits 7:0 are data; widths other than 9 are unsupported.
OFFSET_BASIS, 32'h811C9DC5, hash reset/seed value.
FNV_PRIME, 32'h01000193, multiplier; the shift-add structure is fixed to this value.
CNT_WIDTH, 16, byte counter width.

Ports:
rclk  input  1  read-domain clock, the only clock.
rrst_n  input  1  asynchronous active-low reset.
rdata  input  DSIZE  FIFO head entry, valid whenever rempty=0 (fall-through).
rempty  input  1  FIFO empty.
rinc  output  1  FIFO pop strobe, one cycle per entry.
soft_clr  input  1  synchronous abort/clear of the current message.
digest  output  32  final hash, stable while digest_valid=1.
digest_valid  output  1  digest available.
digest_ready  input  1  consumer accepts digest.
byte_count  output  CNT_WIDTH  bytes folded into the current message, saturating.
busy  output  1  high in MIX or DONE, or while a message is partially hashed (count≠0).

Behaviour:
- Reset (async, rrst_n=0): state=IDLE, hash=OFFSET_BASIS, byte_q=0, last_q=0, rinc=0, digest=0, digest_valid=0, byte_count=0, busy=0.
- States: IDLE, MIX, DONE.
- IDLE, rempty=0: rinc=1 combinationally for exactly this cycle; latch byte_q=rdata[7:0] and last_q=rdata[8]; go to MIX. rinc is never asserted when rempty=1 or outside IDLE.
- IDLE, rempty=1: stay in IDLE.
- MIX (one cycle): hash <= (hash ^ {24'b0,byte_q}) * FNV_PRIME mod 2^32. Implement as x + (x<<1) + (x<<4) + (x<<7) + (x<<8) + (x<<24), with x = hash^byte, all truncated to 32 bits. byte_count increments and saturates at all-ones.
  - last_q=1: digest <= the new hash, digest_valid <= 1, go to DONE.
  - last_q=0: go to IDLE.
- Throughput: 1 byte per 2 clocks. A single-byte message gives digest_valid 2 cycles after the pop cycle.
- DONE: hold digest and digest_valid; no pops. When digest_ready=1: digest_valid <= 0, hash <= OFFSET_BASIS, byte_count <= 0, go to IDLE. digest holds its last value after it is accepted.
- digest_ready is ignored unless digest_valid=1. digest_valid never drops without ready.
- soft_clr=1, state IDLE or MIX: hash <= OFFSET_BASIS, byte_count <= 0, state <= IDLE. Any byte latched for MIX is discarded (already popped, lost by design).
- soft_clr=1, state DONE: ignored; a pending digest is never discarded.
- soft_clr and rempty=0 in the same IDLE cycle: no pop (clear wins).
- Reset mid-message: everything returns to reset values immediately. Upstream FIFO reset is handled separately.

Test Plan:
- Reset, then push {1,"a"=8'h61} -> one rinc pulse; digest_valid 2 cycles later; digest=32'hE40C292C; byte_count=1.
- Push "foobar" with last on 'r', digest_ready held 1 -> exactly 6 rinc pulses, digest=32'hBF9CF968, byte_count=6; next cycle hash reseeded and digest_valid=0.
- Push two messages "a"+last then "foobar"+last back-to-back, digest_ready=0 for 20 cycles -> no rinc while in DONE; digest stays E40C292C; after ready, second digest=BF9CF968.
- Push "fo", pulse soft_clr, then push "a"+last -> digest=E40C292C; no residue of "fo".
- Assert rrst_n=0 during MIX of "foobar" -> all outputs go to reset values asynchronously; after release, "a"+last -> E40C292C.
- Random rempty toggling with the fall-through model -> rinc never high while rempty=1, and exactly one pop per byte.
